// File: rtl/ring_osc_freq_counter.sv
// Ring-oscillator frequency counter: counts clk_div cycles during a synchronised gate window
// and returns the result over a four-phase valid/ack handshake. Optional: RING_OSC_FREQ_CONT_EN.
module ring_osc_freq_counter #(
  parameter int unsigned COUNT_WIDTH = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk_div,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   gate,
  input  logic                   count_ack,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   count_valid,
  output logic                   overflow,
  output logic                   busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_RISE,
    ST_COUNT,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] start_sync_q, start_sync_d;
  logic [SYNC_STAGES-1:0] gate_sync_q, gate_sync_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   start_s_d_q, start_s_d_d;
  logic [COUNT_WIDTH-1:0] counter_q, counter_d;
  logic [COUNT_WIDTH-1:0] count_out_q, count_out_d;
  logic                   count_valid_q, count_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;

  logic start_s, gate_s, ack_s, start_rise;

  always_comb begin
    start_sync_d = {start_sync_q[SYNC_STAGES-2:0], start};
    gate_sync_d  = {gate_sync_q[SYNC_STAGES-2:0], gate};
    ack_sync_d   = {ack_sync_q[SYNC_STAGES-2:0], count_ack};
  end

  assign start_s     = start_sync_q[SYNC_STAGES-1];
  assign gate_s      = gate_sync_q[SYNC_STAGES-1];
  assign ack_s       = ack_sync_q[SYNC_STAGES-1];
  assign start_s_d_d = start_s;
  assign start_rise  = start_s & ~start_s_d_q;

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    count_out_d   = count_out_q;
    count_valid_d = count_valid_q;
    overflow_d    = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d    = ST_ARM;
          overflow_d = 1'b0;
        end
      end
      ST_ARM: begin
        // A window already open at start is skipped: wait for gate low first.
        if (!start_s)     state_d = ST_IDLE;
        else if (!gate_s) state_d = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (!start_s) begin
          state_d = ST_IDLE;
        end else if (gate_s) begin
          state_d   = ST_COUNT;
          counter_d = COUNT_WIDTH'(1);
        end
      end
      ST_COUNT: begin
        if (!start_s) begin
          state_d = ST_IDLE;
        end else if (gate_s) begin
          if (counter_q == '1) overflow_d = 1'b1;
          else                 counter_d  = counter_q + COUNT_WIDTH'(1);
        end else begin
          count_out_d   = counter_q;
          count_valid_d = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ack_s) begin
          count_valid_d = 1'b0;
          state_d       = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
`ifdef RING_OSC_FREQ_CONT_EN
          if (start_s) begin
            state_d    = ST_ARM;
            overflow_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      start_sync_q  <= '0;
      gate_sync_q   <= '0;
      ack_sync_q    <= '0;
      start_s_d_q   <= 1'b0;
      counter_q     <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_sync_q  <= start_sync_d;
      gate_sync_q   <= gate_sync_d;
      ack_sync_q    <= ack_sync_d;
      start_s_d_q   <= start_s_d_d;
      counter_q     <= counter_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
    end
  end

  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign overflow    = overflow_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Directed self-checking bench for ring_osc_freq_counter; a 4-bit instance shares the stimulus
// to exercise saturation.
module tb_ring_osc_freq_counter;

  logic        clk_div = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        gate = 1'b0;
  logic        count_ack = 1'b0;
  logic [23:0] count_out;
  logic        count_valid, overflow, busy;
  logic [3:0]  count_out_s;
  logic        count_valid_s, overflow_s, busy_s;

  int checks = 0;
  int errors = 0;

  always #5 clk_div = ~clk_div;

  ring_osc_freq_counter #(.COUNT_WIDTH(24), .SYNC_STAGES(2)) dut (
    .clk_div(clk_div), .reset_n(reset_n), .start(start), .gate(gate), .count_ack(count_ack),
    .count_out(count_out), .count_valid(count_valid), .overflow(overflow), .busy(busy)
  );

  ring_osc_freq_counter #(.COUNT_WIDTH(4), .SYNC_STAGES(2)) dut_small (
    .clk_div(clk_div), .reset_n(reset_n), .start(start), .gate(gate), .count_ack(count_ack),
    .count_out(count_out_s), .count_valid(count_valid_s), .overflow(overflow_s), .busy(busy_s)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk_div);
  endtask

  task automatic gate_window(input int n);
    gate = 1'b1;
    tick(n);
    gate = 1'b0;
  endtask

  task automatic arm_start();
    start = 1'b0;
    tick(2);
    start = 1'b1;
    tick(8);
  endtask

  task automatic wait_valid(input logic level, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (count_valid === level) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic handshake(output bit dropped);
    count_ack = 1'b1;
    wait_valid(1'b0, dropped);
    count_ack = 1'b0;
    tick(6);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    checks++; if (count_out !== 24'd0) begin errors++; $display("FAIL reset_count_out got=%0d exp=0", count_out); end
    checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", count_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
    tick(3);
  endtask

  task automatic test_basic();
    bit ok;
    arm_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_armed got=%b exp=1", busy); end
    gate_window(100);
    wait_valid(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_valid_timeout got=0 exp=1"); end
    checks++; if (count_out !== 24'd100) begin errors++; $display("FAIL basic_count got=%0d exp=100", count_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got=%b exp=0", overflow); end
    handshake(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_valid_drop got=1 exp=0"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got=%b exp=0", busy); end
    start = 1'b0;
    tick(4);
  endtask

  task automatic test_partial_window();
    bit ok;
    gate = 1'b1;
    tick(5);
    start = 1'b1;
    tick(35);
    gate = 1'b0;
    tick(10);
    gate_window(25);
    wait_valid(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL partial_valid_timeout got=0 exp=1"); end
    checks++; if (count_out !== 24'd25) begin errors++; $display("FAIL partial_count got=%0d exp=25", count_out); end
    handshake(ok);
    start = 1'b0;
    tick(4);
  endtask

  task automatic test_saturation();
    bit ok;
    arm_start();
    gate_window(20);
    wait_valid(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_valid_timeout got=0 exp=1"); end
    checks++; if (count_out !== 24'd20) begin errors++; $display("FAIL sat_wide_count got=%0d exp=20", count_out); end
    checks++; if (count_out_s !== 4'd15) begin errors++; $display("FAIL sat_small_count got=%0d exp=15", count_out_s); end
    checks++; if (overflow_s !== 1'b1) begin errors++; $display("FAIL sat_small_overflow got=%b exp=1", overflow_s); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_wide_overflow got=%b exp=0", overflow); end
    handshake(ok);
    start = 1'b0;
    tick(4);
    arm_start();
    gate_window(3);
    wait_valid(1'b1, ok);
    checks++; if (count_out_s !== 4'd3) begin errors++; $display("FAIL sat_small_count2 got=%0d exp=3", count_out_s); end
    checks++; if (overflow_s !== 1'b0) begin errors++; $display("FAIL sat_small_overflow2 got=%b exp=0", overflow_s); end
    handshake(ok);
    start = 1'b0;
    tick(4);
  endtask

  task automatic test_ack_while_counting();
    bit ok;
    arm_start();
    gate = 1'b1;
    for (int i = 0; i < 30; i++) begin
      count_ack = (i % 8) >= 4;
      tick(1);
    end
    gate = 1'b0;
    count_ack = 1'b0;
    wait_valid(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ackcount_valid_timeout got=0 exp=1"); end
    checks++; if (count_out !== 24'd30) begin errors++; $display("FAIL ackcount_count got=%0d exp=30", count_out); end
    handshake(ok);
    start = 1'b0;
    tick(4);
  endtask

  task automatic test_abort();
    bit seen;
    seen = 1'b0;
    arm_start();
    gate = 1'b1;
    tick(10);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= (count_valid === 1'b1);
      tick(1);
    end
    gate = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= (count_valid === 1'b1);
      tick(1);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_valid got=1 exp=0"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (count_out !== 24'd30) begin errors++; $display("FAIL abort_count_kept got=%0d exp=30", count_out); end
  endtask

  task automatic test_reset_in_hold();
    bit ok;
    arm_start();
    gate_window(7);
    wait_valid(1'b1, ok);
    checks++; if (count_out !== 24'd7) begin errors++; $display("FAIL hold_count got=%0d exp=7", count_out); end
    reset_n = 1'b0;
    #1;
    checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL hold_reset_valid got=%b exp=0", count_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_reset_busy got=%b exp=0", busy); end
    checks++; if (count_out !== 24'd0) begin errors++; $display("FAIL hold_reset_count got=%0d exp=0", count_out); end
    start = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    arm_start();
    gate_window(50);
    wait_valid(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout got=0 exp=1"); end
    checks++; if (count_out !== 24'd50) begin errors++; $display("FAIL b2b_first_count got=%0d exp=50", count_out); end
    handshake(ok);
    tick(4);
`ifdef RING_OSC_FREQ_CONT_EN
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_rearm_busy got=%b exp=1", busy); end
    gate_window(60);
    wait_valid(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout got=0 exp=1"); end
    checks++; if (count_out !== 24'd60) begin errors++; $display("FAIL b2b_second_count got=%0d exp=60", count_out); end
    handshake(ok);
`else
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
    seen = 1'b0;
    gate = 1'b1;
    for (int i = 0; i < 60; i++) begin
      seen |= (count_valid === 1'b1);
      tick(1);
    end
    gate = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen |= (count_valid === 1'b1) | (busy === 1'b1);
      tick(1);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL b2b_no_retrigger got=1 exp=0"); end
    checks++; if (count_out !== 24'd50) begin errors++; $display("FAIL b2b_count_kept got=%0d exp=50", count_out); end
`endif
    start = 1'b0;
    tick(6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_window();
    test_saturation();
    test_ack_while_counting();
    test_abort();
    test_reset_in_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_osc_freq_counter.md
Name: ring_osc_freq_counter

Overview:
Measures the divided ring-oscillator clock by counting clk_div cycles during a gate window supplied from the slow system domain. Runs entirely in the clk_div domain. All control inputs are asynchronous to clk_div and are synchronised internally. The count is returned to the slow domain through a four-phase valid/ack handshake, so firmware can characterise oscillator frequency against a known gate period.

Parameters:
COUNT_WIDTH, 24, width of cycle counter and result.
SYNC_STAGES, 2, flop stages on each asynchronous input (start, gate, count_ack); minimum 2.

Ports:
clk_div  input  1  divided ring-oscillator clock; all state on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  async level from system domain; a rising edge requests one measurement.
gate  input  1  async level; high = counting window.
count_ack  input  1  async four-phase acknowledge from reader.
count_out  output  COUNT_WIDTH  measured cycle count; stable while count_valid = 1.
count_valid  output  1  result available.
overflow  output  1  counter saturated during the last measurement; stable with count_out.
busy  output  1  state != IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; counter, count_out, count_valid, overflow, busy all 0; synchroniser flops cleared; start edge-detect history = 0.
- start_s, gate_s, ack_s are the SYNC_STAGES-flop synchronised versions. start_rise = start_s & ~start_s_d (one extra flop).
- IDLE: start_rise -> ARM; clear overflow.
- ARM: wait for gate_s=0 so a partial window is never counted. gate_s=0 -> WAIT_RISE.
- WAIT_RISE: gate_s=1 -> COUNT with counter <= 1.
- COUNT: gate_s=1 -> counter <= counter+1. At all-ones, hold the value and set overflow.
- COUNT: gate_s=0 -> count_out <= counter; count_valid <= 1; state=HOLD.
- Result = number of clk_div rising edges at which gate_s sampled 1. The synchroniser delays both gate edges equally, so the result equals the gate width in clk_div cycles.
- Abort: start_s=0 in ARM, WAIT_RISE or COUNT -> IDLE next cycle. No valid pulse; count_out and overflow keep their previous values.
- HOLD: count_valid=1. ack_s=1 -> count_valid <= 0; state=RELEASE.
- RELEASE: wait ack_s=0 -> IDLE. start is ignored in HOLD and RELEASE.
- count_out changes only on the COUNT->HOLD transition.
- ack_s high while in IDLE/ARM/WAIT_RISE/COUNT has no effect.
- A new measurement needs a fresh start rising edge seen in IDLE. A start held high across the handshake does not retrigger (unless the feature below is enabled).
- busy is a registered decode, 1 in every state except IDLE.
- Reset asserted mid-measurement or mid-handshake: immediate return to the reset values, including dropping count_valid.

Optional Feature:
- Macro: RING_OSC_FREQ_CONT_EN.
- Defined: continuous mode. From RELEASE, when ack_s=0 and start_s=1, go directly to ARM (overflow cleared) instead of IDLE. This gives back-to-back measurements while start stays high. start_s=0 in RELEASE -> IDLE.
- Undefined: RELEASE always -> IDLE, and a new start rising edge is required.

Test Plan:
- Reset with all inputs 0 -> all outputs 0. Pulse start, drive gate high for exactly 100 clk_div cycles, then low -> count_valid=1, count_out=100, overflow=0. Raise ack -> valid drops; drop ack -> busy=0.
- Gate already high when start rises, stays high 40 cycles, low 10, then high 25 -> first partial window ignored; count_out=25.
- COUNT_WIDTH=4, gate high 20 cycles -> count_out=15, overflow=1. Next measurement of 3 cycles -> count_out=3, overflow=0.
- Start dropped while gate high mid-count -> return to IDLE; count_valid never asserts; count_out keeps its prior value. reset_n pulsed during HOLD -> count_valid=0 and state IDLE immediately.
- start held high through two gate windows of 50 and 60 cycles, with ack handshakes. Without the macro -> only 50 reported. With RING_OSC_FREQ_CONT_EN -> 50 then 60 reported.
- Toggle ack while counting (gate high 30 cycles) -> no effect; count_out=30 and valid asserts normally.
